// File: rtl/mmio_arbiter.sv
// Two-master arbiter for the 8-bit MMIO bus: decodes RAM vs. the PORT_ADDR output register.
// Optional macro ARB_FIXED_PRIORITY_EN: M0 always wins simultaneous requests (default: round-robin).
module mmio_arbiter #(
  parameter logic [7:0] PORT_ADDR  = 8'hFF,
  parameter int         RAM_RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       we0,
  input  logic [7:0] addr0,
  input  logic [7:0] wdata0,
  output logic       gnt0,
  output logic       done0,
  output logic [7:0] rdata0,
  input  logic       req1,
  input  logic       we1,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata1,
  output logic       gnt1,
  output logic       done1,
  output logic [7:0] rdata1,
  output logic       ram_we,
  output logic       ram_re,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  output logic [7:0] DataOut,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, DONE} state_t;

  state_t     state_reg, state_next;
  logic [1:0] wait_reg, wait_next;
  logic       owner_reg;
  logic       we_reg;
  logic [7:0] addr_reg;
  logic [7:0] wdata_reg;
  logic [7:0] dout_reg;
  logic [7:0] rdata0_reg, rdata1_reg;

  logic       win;
  logic       accept;
  logic       cap_rd;
  logic [7:0] cap_val;
  logic       port_hit;

  assign port_hit = (addr_reg == PORT_ADDR);

`ifdef ARB_FIXED_PRIORITY_EN
  // M0 takes any tie; with a single requester this reduces to "whoever asked".
  assign win = ~req0;
`else
  logic rr_reg;

  // rr names the master preferred on the next tie: the one not just served.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_reg <= 1'b0;
    end else if (state_reg == DONE) begin
      rr_reg <= ~owner_reg;
    end
  end

  assign win = (req0 & req1) ? rr_reg : req1;
`endif

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    accept     = 1'b0;
    cap_rd     = 1'b0;
    cap_val    = ram_rdata;
    case (state_reg)
      IDLE: begin
        if (req0 | req1) begin
          accept     = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (we_reg || port_hit) begin
          state_next = DONE;
        end else begin
          state_next = RD_WAIT;
          wait_next  = 2'(RAM_RD_LAT - 1);
        end
        if (!we_reg && port_hit) begin
          cap_rd  = 1'b1;
          cap_val = dout_reg;
        end
      end
      RD_WAIT: begin
        // wait_reg counts the remaining RD_WAIT cycles after this one.
        if (wait_reg == 2'd0) begin
          cap_rd     = 1'b1;
          state_next = DONE;
        end else begin
          wait_next = wait_reg - 2'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      wait_reg   <= 2'd0;
      owner_reg  <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= 8'h00;
      wdata_reg  <= 8'h00;
      dout_reg   <= 8'h00;
      rdata0_reg <= 8'h00;
      rdata1_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      // The winner's request is copied once; later input changes cannot disturb it.
      if (accept) begin
        owner_reg <= win;
        we_reg    <= win ? we1 : we0;
        addr_reg  <= win ? addr1 : addr0;
        wdata_reg <= win ? wdata1 : wdata0;
      end
      if (state_reg == ACCESS && we_reg && port_hit) begin
        dout_reg <= wdata_reg;
      end
      if (cap_rd) begin
        if (owner_reg) begin
          rdata1_reg <= cap_val;
        end else begin
          rdata0_reg <= cap_val;
        end
      end
    end
  end

  assign busy      = (state_reg != IDLE);
  assign gnt0      = busy & ~owner_reg;
  assign gnt1      = busy & owner_reg;
  assign done0     = (state_reg == DONE) & ~owner_reg;
  assign done1     = (state_reg == DONE) & owner_reg;
  assign ram_we    = (state_reg == ACCESS) & we_reg & ~port_hit;
  assign ram_re    = (state_reg == ACCESS) & ~we_reg & ~port_hit;
  assign ram_addr  = addr_reg;
  assign ram_wdata = wdata_reg;
  assign DataOut   = dout_reg;
  assign rdata0    = rdata0_reg;
  assign rdata1    = rdata1_reg;

endmodule

// File: doc/mmio_arbiter.md
Name: mmio_arbiter

Overview:
- Shares the 8-bit memory-mapped data bus between two requesters: M0 (CPU load/store path) and M1 (secondary master, e.g. switch-driven loader or debug).
- Decodes each access to either data RAM or the parallel output register at PORT_ADDR, which this block owns.
- Sequences RAM write-enable and read-latency wait states.
- Hands back read data with a one-cycle done pulse.

Parameters:
- PORT_ADDR, 8'hFF, address of the parallel output register.
- RAM_RD_LAT, 1, RAM read latency in cycles; legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  M0 transaction request; held until done0.
- we0  in  1  M0 write (1) / read (0).
- addr0  in  8  M0 address.
- wdata0  in  8  M0 write data.
- gnt0  out  1  M0 owns the bus (level, for the whole transaction).
- done0  out  1  M0 transaction complete (one-cycle pulse).
- rdata0  out  8  M0 read data; valid when done0=1 and held until the next M0 read completes.
- req1, we1, addr1, wdata1, gnt1, done1, rdata1: same as M0, for M1.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read strobe.
- ram_addr  out  8  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, valid RAM_RD_LAT cycles after ram_re.
- DataOut  out  8  parallel output register.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (synchronous): state=IDLE, rr=0 (M0 preferred), and the following outputs clear to 0: DataOut, rdata0, rdata1, gnt0/1, done0/1, ram_we, ram_re, ram_addr, ram_wdata, busy.
- Reset mid-transaction: abort with no done pulse. A RAM write already issued stands; any other pending effect is dropped.
- FSM states: IDLE, ACCESS, RD_WAIT, DONE.
- IDLE: if any req is high, choose the owner.
  - Only one req high: that master wins.
  - Both high: the master indicated by rr wins.
  - On the edge: latch owner, we, addr, wdata; set gnt_owner=1; go to ACCESS.
- ACCESS (1 cycle): ram_addr and ram_wdata come from the latched values.
  - Write, addr==PORT_ADDR: DataOut <= wdata at end of cycle; ram_we=0; go to DONE.
  - Write, other address: ram_we=1 for exactly this cycle; go to DONE.
  - Read, addr==PORT_ADDR: rdata_owner <= DataOut; go to DONE.
  - Read, other address: ram_re=1 for this cycle; go to RD_WAIT.
- RD_WAIT: stays for RAM_RD_LAT cycles.
  - On the last cycle: rdata_owner <= ram_rdata; go to DONE.
  - ram_addr is held stable throughout.
- DONE (1 cycle): done_owner=1; gnt_owner drops at end of cycle; rr <= other master; go to IDLE.
- Latency, counted from the IDLE cycle in which the request is accepted:
  - done at +2 for writes and port reads.
  - done at +2+RAM_RD_LAT for RAM reads.
- Back-to-back: a request still high in the IDLE cycle after DONE is treated as a new transaction. Masters must drop req in the DONE cycle if they have no further request.
- The loser's req is ignored until the next IDLE; its inputs are not sampled.
- Changes to a master's req, we, addr, or wdata after acceptance are ignored, because the latched copies are used.
- DataOut changes only on an accepted write to PORT_ADDR.
- gnt0 and gnt1 are never both high.

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
- Defined: M0 always wins simultaneous requests; rr is not used.
- Undefined (default): round-robin as described above.
- With a single requester, behaviour is identical in both cases.

Test Plan:
- Reset, then M0 write addr=8'hFF wdata=8'hA5 → DataOut=8'hA5 two cycles after acceptance; ram_we never asserted; done0 pulses once.
- M1 write addr=8'h10 wdata=8'h3C → ram_we=1 for exactly 1 cycle with ram_addr=8'h10, ram_wdata=8'h3C; then done1.
- M0 read addr=8'h10 with RAM_RD_LAT=2 (model returns 8'h3C) → done0 at acceptance+4; rdata0=8'h3C.
- req0 and req1 high continuously, each addressing 8'hFF → grants alternate M0, M1, M0, M1.
  - Without ARB_FIXED_PRIORITY_EN: as above.
  - With ARB_FIXED_PRIORITY_EN: M0 granted every transaction and M1 starved.
- Assert reset in RD_WAIT → no done pulse; state IDLE the next cycle; DataOut=0; rr=0.
- M0 read addr=8'hFF after DataOut=8'h5A, while M1 changes addr1 mid-transaction → rdata0=8'h5A; M1 is served afterwards using its addr1 value sampled in the next IDLE.
